// File: rtl/masked_bus_unmasker_pkg.sv
// -----------------------------------------------------------------------------
// masked_bus_unmasker_pkg
// Layout helpers shared by the masked-gadget blocks so that every block agrees
// on where bit i of share s lives on an interleaved bus and on a share-major
// bus, and on how a chunk-order reversal maps bit positions.
//   shbus_idx      : interleaved bus index, bit i of share s -> i*D + s
//   shares_idx     : share-major bus index, bit i of share s -> s*COUNT + i
//   rev_chunk_idx  : source bit feeding output bit j after chunk reversal
// -----------------------------------------------------------------------------
package masked_bus_unmasker_pkg;

    // Interleaved (bit-major) sharing bus position of bit i of share s.
    function automatic int shbus_idx(input int i, input int s, input int d);
        return i * d + s;
    endfunction

    // Share-major sharing bus position of bit i of share s.
    function automatic int shares_idx(input int i, input int s, input int count);
        return s * count + i;
    endfunction

    // Source bit for output bit j when the chunk order of a word of n chunks
    // is reversed; the bit position inside its chunk is kept.
    function automatic int rev_chunk_idx(input int j, input int chunk, input int n);
        return (n - 1 - (j / chunk)) * chunk + (j % chunk);
    endfunction

endpackage : masked_bus_unmasker_pkg

// File: rtl/masked_bus_unmasker_xor_reduce.sv
// -----------------------------------------------------------------------------
// share_xor_reduce
// Recombines a share-major sharing bus into the unmasked value by XORing the
// D shares of every bit position. Purely combinational.
// Ports:
//   shares : COUNT*D share-major bus, bit s*COUNT+i = bit i of share s
//   data   : COUNT-bit recombined value
// -----------------------------------------------------------------------------
module share_xor_reduce
    import masked_bus_unmasker_pkg::*;
#(
    parameter int D     = 2,
    parameter int COUNT = 128
) (
    input  logic [COUNT*D-1:0] shares,
    output logic [COUNT-1:0]   data
);

    for (genvar i = 0; i < COUNT; i++) begin : g_bit
        logic [D-1:0] column_s;

        // Gather the D share bits that belong to unmasked bit i.
        for (genvar s = 0; s < D; s++) begin : g_share
            assign column_s[s] = shares[shares_idx(i, s, COUNT)];
        end

        assign data[i] = ^column_s;
    end

endmodule : share_xor_reduce

// File: rtl/masked_bus_unmasker.sv
// -----------------------------------------------------------------------------
// masked_bus_unmasker
// Registered unmasking stage for D-share masked buses. The interleaved input
// bus is de-interleaved into share-major layout, the shares are recombined by
// XOR and, when REVERSE=1, the chunk (byte) order of the result is reversed so
// it lines up with byte-serialised reference vectors. One register stage;
// latency is exactly one cycle and a word can be accepted every cycle.
// Ports:
//   clk        : clock, rising edge
//   rst        : synchronous active-high reset, wins over in_valid
//   in_valid   : input word present
//   in_shbus   : COUNT*D interleaved bus, bit i*D+s = bit i of share s
//   out_valid  : registered in_valid
//   out_shares : COUNT*D share-major bus, bit s*COUNT+i = bit i of share s
//   out_data   : COUNT-bit recombined value, chunk-reversed when REVERSE=1
// -----------------------------------------------------------------------------
module masked_bus_unmasker
    import masked_bus_unmasker_pkg::*;
#(
    parameter int D       = 2,
    parameter int COUNT   = 128,
    parameter int CHUNK   = 8,
    parameter int REVERSE = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic [COUNT*D-1:0] in_shbus,
    output logic               out_valid,
    output logic [COUNT*D-1:0] out_shares,
    output logic [COUNT-1:0]   out_data
);

    localparam int N_CHUNKS = (CHUNK > 0) ? (COUNT / CHUNK) : 1;

    if ((D < 1) || (CHUNK < 1) || ((COUNT % CHUNK) != 0)) begin : g_bad_param
        $fatal(1, "masked_bus_unmasker: need D>=1 and COUNT a multiple of CHUNK");
    end

    logic [COUNT*D-1:0] shares_s;
    logic [COUNT-1:0]   recomb_s;
    logic [COUNT-1:0]   ordered_s;

    // De-interleave: pure wiring from bit-major to share-major layout.
    for (genvar s = 0; s < D; s++) begin : g_deint_share
        for (genvar i = 0; i < COUNT; i++) begin : g_deint_bit
            assign shares_s[shares_idx(i, s, COUNT)] = in_shbus[shbus_idx(i, s, D)];
        end
    end

    share_xor_reduce #(
        .D     (D),
        .COUNT (COUNT)
    ) u_xor_reduce (
        .shares (shares_s),
        .data   (recomb_s)
    );

    // Chunk reversal is wiring only; with a single chunk it degenerates to
    // the identity mapping.
    if (REVERSE == 1) begin : g_reverse
        for (genvar j = 0; j < COUNT; j++) begin : g_rev_bit
            assign ordered_s[j] = recomb_s[rev_chunk_idx(j, CHUNK, N_CHUNKS)];
        end
    end else begin : g_no_reverse
        assign ordered_s = recomb_s;
    end

    // Output register: data loads every cycle regardless of in_valid, so the
    // outputs always show the previous cycle's bus; reset clears everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_shares <= '0;
            out_data   <= '0;
        end else begin
            out_valid  <= in_valid;
            out_shares <= shares_s;
            out_data   <= ordered_s;
        end
    end

endmodule : masked_bus_unmasker

// File: tb/tb_masked_bus_unmasker.sv
// -----------------------------------------------------------------------------
// tb_masked_bus_unmasker
// Directed bench with hand-computed expectations for four configurations:
//   u_a : D=2, COUNT=8,   CHUNK=8, REVERSE=1 (recombine, streaming, reset)
//   u_b : D=1, COUNT=16,  CHUNK=8, REVERSE=1 (byte reversal)
//   u_c : D=1, COUNT=16,  CHUNK=8, REVERSE=0 (reversal bypassed)
//   u_d : D=2, COUNT=128, CHUNK=8, REVERSE=1 (AES word)
// -----------------------------------------------------------------------------
module tb_masked_bus_unmasker;

    logic clk;
    logic rst;

    logic         a_in_valid;
    logic [15:0]  a_in_shbus;
    logic         a_out_valid;
    logic [15:0]  a_out_shares;
    logic [7:0]   a_out_data;

    logic         b_in_valid;
    logic [15:0]  b_in_shbus;
    logic         b_out_valid;
    logic [15:0]  b_out_shares;
    logic [15:0]  b_out_data;

    logic         c_in_valid;
    logic [15:0]  c_in_shbus;
    logic         c_out_valid;
    logic [15:0]  c_out_shares;
    logic [15:0]  c_out_data;

    logic         d_in_valid;
    logic [255:0] d_in_shbus;
    logic         d_out_valid;
    logic [255:0] d_out_shares;
    logic [127:0] d_out_data;

    int checks_cnt;
    int errors_cnt;

    masked_bus_unmasker #(.D(2), .COUNT(8), .CHUNK(8), .REVERSE(1)) u_a (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (a_in_valid),
        .in_shbus   (a_in_shbus),
        .out_valid  (a_out_valid),
        .out_shares (a_out_shares),
        .out_data   (a_out_data)
    );

    masked_bus_unmasker #(.D(1), .COUNT(16), .CHUNK(8), .REVERSE(1)) u_b (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (b_in_valid),
        .in_shbus   (b_in_shbus),
        .out_valid  (b_out_valid),
        .out_shares (b_out_shares),
        .out_data   (b_out_data)
    );

    masked_bus_unmasker #(.D(1), .COUNT(16), .CHUNK(8), .REVERSE(0)) u_c (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (c_in_valid),
        .in_shbus   (c_in_shbus),
        .out_valid  (c_out_valid),
        .out_shares (c_out_shares),
        .out_data   (c_out_data)
    );

    masked_bus_unmasker #(.D(2), .COUNT(128), .CHUNK(8), .REVERSE(1)) u_d (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (d_in_valid),
        .in_shbus   (d_in_shbus),
        .out_valid  (d_out_valid),
        .out_shares (d_out_shares),
        .out_data   (d_out_data)
    );

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [255:0] observed,
                               input logic [255:0] expected);
        checks_cnt = checks_cnt + 1;
        if (observed !== expected) begin
            errors_cnt = errors_cnt + 1;
            $display("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] interleave8(input logic [7:0] s0, input logic [7:0] s1);
        logic [15:0] r;
        for (int i = 0; i < 8; i++) begin
            r[2*i]   = s0[i];
            r[2*i+1] = s1[i];
        end
        return r;
    endfunction

    function automatic logic [255:0] interleave128(input logic [127:0] s0, input logic [127:0] s1);
        logic [255:0] r;
        for (int i = 0; i < 128; i++) begin
            r[2*i]   = s0[i];
            r[2*i+1] = s1[i];
        end
        return r;
    endfunction

    localparam logic [127:0] AES_S0  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] AES_REV = 128'h320b6a19978511dcfb09dc021d842539;
    localparam logic [127:0] MASK_R  = 128'h0123456789abcdeffedcba9876543210;

    logic [7:0] st_s0  [5];
    logic [7:0] st_s1  [5];
    logic [7:0] st_exp [5];

    initial begin
        checks_cnt = 0;
        errors_cnt = 0;
        clk        = 1'b0;

        st_s0[0] = 8'h00; st_s1[0] = 8'hFF; st_exp[0] = 8'hFF;
        st_s0[1] = 8'h3C; st_s1[1] = 8'h3C; st_exp[1] = 8'h00;
        st_s0[2] = 8'h81; st_s1[2] = 8'h18; st_exp[2] = 8'h99;
        st_s0[3] = 8'h55; st_s1[3] = 8'h0A; st_exp[3] = 8'h5F;
        st_s0[4] = 8'h12; st_s1[4] = 8'h34; st_exp[4] = 8'h26;

        // Reset with valid high and all-ones buses: everything must clear.
        rst        = 1'b1;
        a_in_valid = 1'b1; a_in_shbus = '1;
        b_in_valid = 1'b1; b_in_shbus = '1;
        c_in_valid = 1'b1; c_in_shbus = '1;
        d_in_valid = 1'b1; d_in_shbus = '1;
        tick();
        check_value("rst_a_valid",  256'(a_out_valid),  256'(1'b0));
        check_value("rst_a_shares", 256'(a_out_shares), 256'(16'h0000));
        check_value("rst_a_data",   256'(a_out_data),   256'(8'h00));
        check_value("rst_b_data",   256'(b_out_data),   256'(16'h0000));
        check_value("rst_d_valid",  256'(d_out_valid),  256'(1'b0));
        check_value("rst_d_shares", d_out_shares,       256'(1'b0));
        check_value("rst_d_data",   256'(d_out_data),   256'(1'b0));

        // De-interleave / recombine / reversal vectors.
        rst        = 1'b0;
        a_in_shbus = 16'h44BB;
        b_in_shbus = 16'h1234;
        c_in_shbus = 16'h1234;
        d_in_shbus = interleave128(AES_S0, 128'h0);
        tick();
        check_value("deint_a_valid",  256'(a_out_valid),  256'(1'b1));
        check_value("deint_a_shares", 256'(a_out_shares), 256'(16'h0FA5));
        check_value("deint_a_data",   256'(a_out_data),   256'(8'hAA));
        check_value("rev_b_data",     256'(b_out_data),   256'(16'h3412));
        check_value("rev_b_shares",   256'(b_out_shares), 256'(16'h1234));
        check_value("norev_c_data",   256'(c_out_data),   256'(16'h1234));
        check_value("aes_d_data",     256'(d_out_data),   256'(AES_REV));
        check_value("aes_d_shares",   d_out_shares,       {128'h0, AES_S0});

        // Remask the AES word: the recombined value must not move.
        d_in_shbus = interleave128(AES_S0 ^ MASK_R, MASK_R);
        tick();
        check_value("aes_mask_data",   256'(d_out_data), 256'(AES_REV));
        check_value("aes_mask_shares", d_out_shares,     {MASK_R, AES_S0 ^ MASK_R});

        // Five back-to-back words, then one idle slot with a known bus.
        for (int k = 0; k < 5; k++) begin
            a_in_valid = 1'b1;
            a_in_shbus = interleave8(st_s0[k], st_s1[k]);
            tick();
            check_value("stream_valid",  256'(a_out_valid),  256'(1'b1));
            check_value("stream_data",   256'(a_out_data),   256'(st_exp[k]));
            check_value("stream_shares", 256'(a_out_shares), 256'({st_s1[k], st_s0[k]}));
        end
        a_in_valid = 1'b0;
        a_in_shbus = interleave8(8'hC3, 8'h00);
        tick();
        check_value("idle_valid", 256'(a_out_valid), 256'(1'b0));
        check_value("idle_data",  256'(a_out_data),  256'(8'hC3));

        // Reset asserted while the third word is presented.
        for (int k = 0; k < 2; k++) begin
            a_in_valid = 1'b1;
            a_in_shbus = interleave8(st_s0[k], st_s1[k]);
            tick();
            check_value("pre_rst_data", 256'(a_out_data), 256'(st_exp[k]));
        end
        rst        = 1'b1;
        a_in_shbus = interleave8(st_s0[2], st_s1[2]);
        tick();
        check_value("midrst_valid",  256'(a_out_valid),  256'(1'b0));
        check_value("midrst_data",   256'(a_out_data),   256'(8'h00));
        check_value("midrst_shares", 256'(a_out_shares), 256'(16'h0000));
        rst = 1'b0;
        for (int k = 3; k < 5; k++) begin
            a_in_shbus = interleave8(st_s0[k], st_s1[k]);
            tick();
            check_value("resume_valid", 256'(a_out_valid), 256'(1'b1));
            check_value("resume_data",  256'(a_out_data),  256'(st_exp[k]));
        end

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

endmodule : tb_masked_bus_unmasker

// File: doc/masked_bus_unmasker.md
Name: masked_bus_unmasker

Overview:
- Registered unmasking stage for masked (d-share) buses in the SMAesH test and debug infrastructure.
- Accepts a bit-interleaved sharing bus and de-interleaves it into a share-major layout.
- Recombines the shares by XOR and optionally reverses chunk (byte) order, so the result can be compared against byte-serialised reference vectors.
- One pipeline register stage with a valid flag.

Parameters:
- D, 2, number of shares (>=1).
- COUNT, 128, unmasked data width in bits.
- CHUNK, 8, granularity of the order reversal in bits; COUNT must be a multiple of CHUNK.
- REVERSE, 1, 1 = output chunk order reversed; 0 = reversal bypassed.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input word is present this cycle.
- in_shbus  in  COUNT*D  interleaved sharing bus; bit i*D+s = bit i of share s.
- out_valid  out  1  registered copy of in_valid.
- out_shares  out  COUNT*D  share-major layout; bit s*COUNT+i = bit i of share s.
- out_data  out  COUNT  XOR of all D shares, chunk-reversed when REVERSE=1.

Behaviour:
- Reset values: out_valid=0, out_shares=0, out_data=0, forced on any rising edge with rst=1. rst has priority over in_valid; reset mid-stream drops the word in flight.
- Otherwise, every cycle:
  - out_valid <= in_valid.
  - The data registers load unconditionally, whatever in_valid is. The output therefore always reflects the previous cycle's in_shbus.
- Latency: exactly 1 cycle. There is no ready/back-pressure; a new word can be accepted every cycle.
- De-interleave: shares[s*COUNT+i] = in_shbus[i*D+s] for all s<D, i<COUNT. This is pure wiring.
- Recombine: r[i] = XOR over s of shares[s*COUNT+i]. With D=1, r equals the input.
- Chunk reverse, for REVERSE=1 with N=COUNT/CHUNK:
  - rev[k*CHUNK +: CHUNK] = r[(N-1-k)*CHUNK +: CHUNK] for k<N.
  - Bit order inside a chunk is preserved.
  - When N=1 the reversal is the identity.
- The reversal is an involution: applying it twice restores the word.
- out_shares is registered from the de-interleaved value, not the reversed one.
- All combinational logic sits before the register; no combinational path runs from inputs to outputs.
- Elaboration check: COUNT%CHUNK!=0 or D<1 causes a fatal elaboration error.

Decomposition:
- Shared package:
  - index helper functions shbus_idx(i,s,D)=i*D+s and shares_idx(i,s,COUNT)=s*COUNT+i.
  - chunk-reverse index helper.
  - These keep the layout convention identical across all masked-gadget blocks.
- One natural sub-module: share_xor_reduce (parameters D, COUNT; share-major input, COUNT-bit XOR output), built as a generate loop.
- De-interleave and reverse stay inline as generate wiring.

Test Plan:
- Reset:
  - Drive rst=1 for one cycle with in_valid=1 and in_shbus=all ones.
  - Next cycle: out_valid=0, out_data=0, out_shares=0.
- De-interleave and recombine (D=2, COUNT=8, CHUNK=8):
  - in_shbus=0x44BB, i.e. share0=0xA5, share1=0x0F.
  - One cycle later: out_shares=0x0FA5, out_data=0xAA, out_valid=1.
- Reversal (D=1, COUNT=16, REVERSE=1):
  - in_shbus=0x1234 → out_data=0x3412.
  - With REVERSE=0 → out_data=0x1234.
- AES word (D=2, COUNT=128):
  - share0 = 0x3925841d02dc09fbdc118597196a0b32, share1 = 0, interleaved.
  - → out_data=0x320b6a19978511dcfb09dc021d842539.
  - Then share1=random R with share0 XOR R fixed: out_data unchanged.
- Streaming:
  - 5 back-to-back valid words, then one idle cycle with in_valid=0.
  - out_valid=1 for exactly 5 cycles, each output delayed by 1 cycle.
  - out_valid=0 in the idle slot; outputs carry no bubbles and no reordering.
- Reset mid-stream: assert rst during the third word → out_valid=0 the following cycle; streaming resumes one cycle after rst deasserts.
